// File: rtl/riscv_data_mem_pkg.sv
// Shared RV32I load/store definitions for the data memory responder.
package riscv_data_mem_pkg;

  // Load funct3 encodings
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // True when funct3 names a real RV32I access of the given direction
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
    else
      return (f3 == FUNCT3_LB)  || (f3 == FUNCT3_LH)  || (f3 == FUNCT3_LW) ||
             (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
  endfunction

endpackage

// File: rtl/riscv_mem_lane.sv
// Byte-lane steering: store byte enables and merge, load lane select and
// sign/zero extension, and alignment check. Purely combinational.
module riscv_mem_lane
  import riscv_data_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_ldval,
  output logic        o_misalign
);

  logic [31:0] w_shift;
  logic [31:0] w_rep;

  // Bring the addressed lane down to bit 0 for extension
  assign w_shift = i_word >> {i_addr, 3'b000};

  // Decode access size from funct3[1:0]; funct3[2] selects zero-extension
  always_comb begin
    o_be       = 4'b0000;
    o_misalign = 1'b0;
    w_rep      = i_wdata;
    o_ldval    = '0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr;
        w_rep   = {4{i_wdata[7:0]}};
        o_ldval = i_funct3[2] ? {24'b0, w_shift[7:0]}
                              : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        o_be       = i_addr[1] ? 4'b1100 : 4'b0011;
        w_rep      = {2{i_wdata[15:0]}};
        o_misalign = i_addr[0];
        o_ldval    = i_funct3[2] ? {16'b0, w_shift[15:0]}
                                 : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      2'b10: begin
        o_be       = 4'b1111;
        o_misalign = |i_addr;
        o_ldval    = i_word;
      end
      default: ;
    endcase
  end

  // Enabled lanes take replicated store data, the rest keep the old word
  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign o_wword[8*i +: 8] = o_be[i] ? w_rep[8*i +: 8] : i_word[8*i +: 8];
  end

endmodule

// File: rtl/riscv_data_mem.sv
// Single-outstanding data memory responder for the hart's MA stage with a
// programmable response latency. Stores commit and loads read at accept.
module riscv_data_mem
  import riscv_data_mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault
);

  localparam int         IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  mem_state_t      r_state, w_next;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;
  logic            r_fault;

  logic            w_accept;
  logic [IDXW-1:0] w_idx;
  logic            w_in_range;
  logic [XLEN-1:0] w_word;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wword;
  logic [XLEN-1:0] w_ldval;
  logic            w_misalign;
  logic            w_fault;
  logic            w_wr_en;

  // Holding rst keeps a request from sneaking into the array during reset
  assign w_accept   = req_valid & req_ready & ~rst;
  assign w_idx      = req_addr[IDXW+1:2];
  assign w_in_range = (req_addr[XLEN-1:2] < (XLEN-2)'(DEPTH));
  // Range check above guards any index the truncated w_idx would alias
  assign w_word     = r_mem[w_idx];

  riscv_mem_lane u_lane (
    .i_funct3   (req_funct3),
    .i_addr     (req_addr[1:0]),
    .i_word     (w_word),
    .i_wdata    (req_wdata),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_ldval    (w_ldval),
    .o_misalign (w_misalign)
  );

  assign w_fault = ~f3_legal(req_write, req_funct3) | w_misalign | ~w_in_range;
  assign w_wr_en = w_accept & req_write & ~w_fault & (|w_be);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
  end

  // Latency counter: loaded at accept, counts down while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_cnt <= 4'd0;
    else if (w_accept)                        r_cnt <= CNT_INIT;
    else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Response payload captured at accept and held until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= w_fault;
      r_rdata <= (w_fault | req_write) ? '0 : w_ldval;
    end
  end

  // Data array: not reset, so committed stores survive a reset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_idx] <= w_wword;
  end

  assign rsp_rdata = r_rdata;
  assign rsp_fault = r_fault;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench: a LATENCY=1 instance driven from a vector table and a
// LATENCY=4 instance for backpressure and reset-in-flight sequences.
module tb_riscv_data_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: LATENCY = 1
  logic        a_req_valid = 0, a_req_ready, a_req_write = 0;
  logic [2:0]  a_req_funct3 = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_rsp_valid, a_rsp_ready = 1, a_rsp_fault;
  logic [31:0] a_rsp_rdata;

  // Instance B: LATENCY = 4
  logic        b_req_valid = 0, b_req_ready, b_req_write = 0;
  logic [2:0]  b_req_funct3 = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic        b_rsp_valid, b_rsp_ready = 0, b_rsp_fault;
  logic [31:0] b_rsp_rdata;

  riscv_data_mem #(.XLEN(32), .DEPTH(1024), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault)
  );

  riscv_data_mem #(.XLEN(32), .DEPTH(1024), .LATENCY(4)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic flt);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rd = rd; v.exp_flt = flt;
    return v;
  endfunction

  // One transaction on A; rsp_ready stays high so RESP lasts one cycle
  task automatic run_a(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd,
                       output logic flt, output int lat);
    int n;
    @(negedge clk);
    a_req_valid = 1; a_req_write = wr; a_req_funct3 = f3;
    a_req_addr = addr; a_req_wdata = wdata;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    a_req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!a_rsp_valid && lat < 20);
    rd = a_rsp_rdata; flt = a_rsp_fault;
  endtask

  // One transaction on B, checking WAIT timing and holding RESP for 'hold' cycles
  task automatic run_b(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] rd, output logic flt);
    int n;
    @(negedge clk);
    b_req_valid = 1; b_req_write = wr; b_req_funct3 = f3;
    b_req_addr = addr; b_req_wdata = wdata; b_rsp_ready = 0;
    n = 0;
    while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept_timeout"}, 32'(n >= 20), 32'd0);
    @(posedge clk); #1;
    b_req_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk({tag, "_rsp_valid_lat"}, 32'(b_rsp_valid), (c == 4) ? 32'd1 : 32'd0);
      chk({tag, "_req_ready_busy"}, 32'(b_req_ready), 32'd0);
    end
    rd = b_rsp_rdata; flt = b_rsp_fault;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(b_rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, b_rsp_rdata, rd);
      chk({tag, "_hold_req_ready"}, 32'(b_req_ready), 32'd0);
    end
    b_rsp_ready = 1;
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(b_rsp_valid), 32'd0);
    chk({tag, "_done_req_ready"}, 32'(b_req_ready), 32'd1);
    b_rsp_ready = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;

    vecs[0]  = mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    vecs[1]  = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    vecs[3]  = mk(0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0);
    vecs[4]  = mk(0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0);
    vecs[5]  = mk(0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0);
    vecs[6]  = mk(1, 3'b000, 32'h11,  32'hAABBCC55, 32'h0,        0);
    vecs[7]  = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0);
    vecs[8]  = mk(0, 3'b010, 32'h12,  32'h0,        32'h0,        1);
    vecs[9]  = mk(1, 3'b001, 32'h13,  32'h00001234, 32'h0,        1);
    vecs[10] = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0);
    vecs[11] = mk(0, 3'b011, 32'h10,  32'h0,        32'h0,        1);
    vecs[12] = mk(1, 3'b100, 32'h10,  32'h0,        32'h0,        1);
    vecs[13] = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0);
    vecs[14] = mk(1, 3'b010, 32'h0,   32'h11223344, 32'h0,        0);
    vecs[15] = mk(1, 3'b010, 32'h1000,32'hAAAAAAAA, 32'h0,        1);
    vecs[16] = mk(0, 3'b010, 32'h1000,32'h0,        32'h0,        1);
    vecs[17] = mk(0, 3'b010, 32'h0,   32'h0,        32'h11223344, 0);
    vecs[18] = mk(1, 3'b001, 32'h2,   32'h0000BEEF, 32'h0,        0);
    vecs[19] = mk(0, 3'b010, 32'h0,   32'h0,        32'hBEEF3344, 0);
    vecs[20] = mk(0, 3'b000, 32'h1,   32'h0,        32'h00000033, 0);
    vecs[21] = mk(0, 3'b001, 32'h2,   32'h0,        32'hFFFFBEEF, 0);
    vecs[22] = mk(1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0,        0);
    vecs[23] = mk(0, 3'b101, 32'hFFE, 32'h0,        32'h0000CAFE, 0);
    vecs[24] = mk(0, 3'b000, 32'hFFC, 32'h0,        32'h0000000D, 0);
    vecs[25] = mk(0, 3'b000, 32'hFFD, 32'h0,        32'hFFFFFFF0, 0);
    vecs[26] = mk(0, 3'b001, 32'hFFD, 32'h0,        32'h0,        1);
    vecs[27] = mk(0, 3'b010, 32'h11,  32'h0,        32'h0,        1);
    vecs[28] = mk(1, 3'b000, 32'h13,  32'h00000080, 32'h0,        0);
    vecs[29] = mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_a_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_a_rsp_fault", 32'(a_rsp_fault), 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    rst = 0;

    // Table-driven vectors on the LATENCY=1 instance
    for (int i = 0; i < NV; i++) begin
      run_a(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].exp_flt));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end

    // LATENCY=4: store, then a load held in RESP for 3 cycles
    run_b("b_sw", 1, 3'b010, 32'h20, 32'h01234567, 0, rd, flt);
    chk("b_sw_rdata", rd, 32'h0);
    chk("b_sw_fault", 32'(flt), 32'd0);
    run_b("b_lw", 0, 3'b010, 32'h20, 32'h0, 3, rd, flt);
    chk("b_lw_rdata", rd, 32'h01234567);
    chk("b_lw_fault", 32'(flt), 32'd0);

    // Store on B, then reset while it is still in WAIT
    run_b("b_sw2", 1, 3'b010, 32'h24, 32'hA5A5A5A5, 0, rd, flt);
    @(negedge clk);
    b_req_valid = 1; b_req_write = 1; b_req_funct3 = 3'b010;
    b_req_addr = 32'h28; b_req_wdata = 32'h5A5A0FF0;
    @(posedge clk); #1;
    b_req_valid = 0;
    repeat (2) @(negedge clk);
    chk("wait_req_ready_pre", 32'(b_req_ready), 32'd0);
    rst = 1; #1;
    chk("midrst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    run_b("b_after_rst_24", 0, 3'b010, 32'h24, 32'h0, 0, rd, flt);
    chk("after_rst_lw24", rd, 32'hA5A5A5A5);
    run_b("b_after_rst_28", 0, 3'b010, 32'h28, 32'h0, 0, rd, flt);
    chk("after_rst_lw28", rd, 32'h5A5A0FF0);

    // A's array also survives the reset
    run_a(0, 3'b010, 32'h10, 32'h0, rd, flt, lat);
    chk("a_after_rst_lw10", rd, 32'h80AD55EF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/riscv_data_mem.md
Name: riscv_data_mem

Overview:
- Memory responder serving the hart's load/store port.
- Accepts one request at a time through a valid/ready handshake and commits stores with RV32I byte/half/word semantics.
- Returns load data sign- or zero-extended after a configurable latency, and flags misaligned, out-of-range or illegal accesses.
- Sits between the hart's MA stage and the data RAM, and lets the bench model slow memory.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
DEPTH, 1024, number of XLEN-bit words in the array.
LATENCY, 1, cycles from accept edge to rsp_valid; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data; low bytes are used for SB/SH
rsp_valid  out  1  response present
rsp_ready  in  1  requester consumes the response
rsp_rdata  out  XLEN  extended load data; 0 for stores and faults
rsp_fault  out  1  access was rejected

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, counter=0. The array is not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready at a rising edge and capture write, funct3, addr and wdata.
  - If LATENCY=1, go straight to RESP; otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter==0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_fault are stable.
  - Hold until rsp_ready=1, then go to IDLE.
  - No request is accepted while in RESP, so throughput is one request per LATENCY+1 cycles at best.
- Timing: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Fault checks, evaluated at accept:
  - Loads: funct3 must be in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 must be in {000 SB, 001 SH, 010 SW}.
  - Halfword accesses need addr[0]==0; word accesses need addr[1:0]==0.
  - The word index addr[XLEN-1:2] must be < DEPTH.
  - Any violation sets rsp_fault=1 and rsp_rdata=0, and suppresses the write.
- Stores:
  - The array is written at the accept edge, little-endian.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes keep their value; rsp_rdata=0.
- Loads:
  - The word is read at the accept edge, before any write from the same edge (a load never coincides with a store).
  - The lane is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The result is held in a register until the response is consumed.
- Ordering: a store's data is visible to any later accepted load.
- Reset mid-operation: returns to IDLE immediately and drops any pending response. A store already committed at its accept edge remains in the array.
- req_valid is ignored outside IDLE. The requester must hold its request stable until req_ready is sampled high.

Decomposition:
- The shared riscv ISA package gains:
  - load funct3 constants FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU;
  - store funct3 constants FUNCT3_SB, FUNCT3_SH, FUNCT3_SW;
  - a mem_state_t enum {IDLE, WAIT, RESP}.
- One combinational sub-module, riscv_mem_lane, holds the lane and extension logic:
  - inputs: funct3, addr[1:0], word, wdata;
  - outputs: byte-enable[3:0], the merged write word, the extended load value, and a misalign flag.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with LATENCY=1 -> rsp_valid one cycle after accept, rsp_rdata=0xDEADBEEF, rsp_fault=0.
- After the word above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF, showing the other lanes are preserved.
- LW 0x12 and SH 0x13 -> rsp_fault=1, rsp_rdata=0; a follow-up LW 0x10 shows the memory is unchanged.
- LATENCY=4 with rsp_ready held low for 3 cycles in RESP -> rsp_valid 4 cycles after accept, rsp_rdata stable throughout, req_ready=0 until the cycle after rsp_ready=1.
- Assert rst during WAIT -> rsp_valid=0 and req_ready=1 immediately; the next LW returns the pre-reset store data.
